// File: rtl/rfsoc_cfg_serializer.sv
// rfsoc_cfg_serializer
//   PL-side sequencer for the RFSoC configuration GPIO bus. Accepts one
//   command per valid/ready handshake and shifts the payload MSB-first on
//   sdata while strobing the serial clock of the selected line, or issues a
//   trigger_line pulse.
//
// Parameters
//   DATA_W : maximum payload bits per command (cmd_len range 1..DATA_W)
//   DIV    : clk cycles per serial-clock half period (>= 1)
//
// Ports
//   clk        : fabric clock, rising edge
//   rst_n      : asynchronous active-low reset
//   cmd_valid  : command present
//   cmd_ready  : idle and accepting
//   cmd_target : bus index (1,2,3,4,7,8 serial clocks; 6 trigger)
//   cmd_len    : number of bits to shift (ignored for trigger)
//   cmd_data   : payload; bit cmd_len-1 goes out first
//   gpio_out   : [0] sdata, [1..4],[7],[8] serial clocks, [5] pl_rst (0),
//                [6] trigger_line
//   done       : one-cycle pulse when a legal command completes
//   err        : one-cycle pulse when an illegal command is accepted
module rfsoc_cfg_serializer #(
  parameter int DATA_W = 256,
  parameter int DIV    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [7:0]        cmd_target,
  input  logic [8:0]        cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  output logic [8:0]        gpio_out,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = $clog2(DIV) + 1;
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  // 2*DIV-1 always fits in clog2(DIV)+1 bits, so the trigger phase can
  // reuse the half-period counter.
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] TRIG_LOAD = CNT_W'(2 * DIV - 1);
  localparam logic [9:0]       MAX_LEN   = 10'(DATA_W);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    HOLD  = 3'd3,
    TRIG  = 3'd4
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [8:0]          r_bits;
  logic [7:0]          r_target;
  logic [DATA_W-1:0]   r_data;
  logic [8:0]          r_gpio;
  logic                r_done;
  logic                r_err;

  state_t              w_state_next;
  logic [CNT_W-1:0]    w_cnt_next;
  logic [8:0]          w_bits_next;
  logic [8:0]          w_gpio_next;
  logic                w_done_next;
  logic                w_err_next;
  logic                w_accept;
  logic                w_shift_tgt;
  logic                w_illegal;
  logic [7:0]          w_tgt;
  logic [DATA_W-1:0]   w_data;
  logic [IDX_W-1:0]    w_bit_idx;
  logic [8:0]          w_sel;

  assign cmd_ready = (r_state == IDLE);
  assign gpio_out  = r_gpio;
  assign done      = r_done;
  assign err       = r_err;

  assign w_accept    = cmd_valid && (r_state == IDLE);
  assign w_shift_tgt = (cmd_target == 8'd1) || (cmd_target == 8'd2) ||
                       (cmd_target == 8'd3) || (cmd_target == 8'd4) ||
                       (cmd_target == 8'd7) || (cmd_target == 8'd8);
  assign w_illegal   = !(w_shift_tgt || (cmd_target == 8'd6)) ||
                       (w_shift_tgt && ((cmd_len == 9'd0) ||
                                        ({1'b0, cmd_len} > MAX_LEN)));

  // Outputs are registered from the next state, so on the accepting edge the
  // bus must already see the incoming command rather than the latched one.
  assign w_tgt  = w_accept ? cmd_target : r_target;
  assign w_data = w_accept ? cmd_data   : r_data;

  // The bit counter holds the number of bits still to send; the current bit
  // is therefore at position count-1.
  assign w_bit_idx = IDX_W'(w_bits_next - 9'd1);

  // One-hot decode of the target onto the bus; bus bit index equals target.
  assign w_sel[0] = 1'b0;
  for (genvar gi = 1; gi <= 8; gi++) begin : g_sel
    assign w_sel[gi] = (w_tgt == 8'(gi));
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_bits_next  = r_bits;
    w_done_next  = 1'b0;
    w_err_next   = 1'b0;
    case (r_state)
      IDLE: begin
        if (cmd_valid) begin
          if (w_illegal) begin
            w_err_next = 1'b1;
          end else if (cmd_target == 8'd6) begin
            w_state_next = TRIG;
            w_cnt_next   = TRIG_LOAD;
          end else begin
            w_state_next = SETUP;
            w_cnt_next   = HALF_LOAD;
            w_bits_next  = cmd_len;
          end
        end
      end
      SETUP: begin
        if (r_cnt == '0) begin
          w_state_next = HIGH;
          w_cnt_next   = HALF_LOAD;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      HIGH: begin
        if (r_cnt == '0) begin
          w_bits_next  = r_bits - 9'd1;
          w_cnt_next   = HALF_LOAD;
          w_state_next = (r_bits == 9'd1) ? HOLD : SETUP;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      HOLD, TRIG: begin
        if (r_cnt == '0) begin
          w_state_next = IDLE;
          w_done_next  = 1'b1;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Bus value for the coming cycle
  always_comb begin
    w_gpio_next = '0;
    case (w_state_next)
      SETUP: begin
        w_gpio_next[0] = w_data[w_bit_idx];
      end
      HIGH: begin
        w_gpio_next[0]   = w_data[w_bit_idx];
        w_gpio_next[8:1] = w_sel[8:1];
      end
      HOLD: begin
        // Last bit stays on sdata through the hold time after the final edge.
        w_gpio_next[0] = r_gpio[0];
      end
      TRIG: begin
        w_gpio_next[6] = 1'b1;
      end
      default: begin
        w_gpio_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_bits   <= '0;
      r_target <= '0;
      r_data   <= '0;
      r_gpio   <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_bits  <= w_bits_next;
      r_gpio  <= w_gpio_next;
      r_done  <= w_done_next;
      r_err   <= w_err_next;
      if (w_accept && !w_illegal) begin
        r_target <= cmd_target;
        r_data   <= cmd_data;
      end
    end
  end

endmodule

// File: tb/tb_rfsoc_cfg_serializer.sv
// Self-checking bench for rfsoc_cfg_serializer (DATA_W=256, DIV=2).
// Expected bus values are computed per cycle from the command timing rules:
// cycle offset n after the accepting edge falls into bit k = (n-1)/(2*DIV),
// clock high in the second half of each bit period, then a DIV-cycle hold.
module tb_rfsoc_cfg_serializer;

  localparam int DATA_W = 256;
  localparam int DIV    = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [7:0]        cmd_target = '0;
  logic [8:0]        cmd_len = '0;
  logic [DATA_W-1:0] cmd_data = '0;
  logic [8:0]        gpio_out;
  logic              done;
  logic              err;

  int total = 0;
  int bad   = 0;

  rfsoc_cfg_serializer #(.DATA_W(DATA_W), .DIV(DIV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_target (cmd_target),
    .cmd_len    (cmd_len),
    .cmd_data   (cmd_data),
    .gpio_out   (gpio_out),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] rand_word();
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // Called at a negedge; returns right after the accepting posedge.
  task automatic send(input logic [7:0] t, input logic [8:0] l, input logic [DATA_W-1:0] d);
    int w;
    cmd_target = t;
    cmd_len    = l;
    cmd_data   = d;
    cmd_valid  = 1'b1;
    w = 0;
    while (cmd_ready !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("accept_wait", 32'(w < 200), 32'd1);
    @(posedge clk);
  endtask

  // Checks every cycle of a shift; stop_at>0 ends early after that offset.
  task automatic expect_shift(input logic [7:0] t, input int l, input logic [DATA_W-1:0] d,
                              input int stop_at);
    int nlast;
    int k;
    int w;
    logic [8:0] e;
    nlast = (2 * l + 1) * DIV;
    for (int n = 1; n <= nlast + 1; n++) begin
      @(negedge clk);
      if (n == 1) cmd_valid = 1'b0;
      e = '0;
      if (n <= nlast) begin
        k = (n - 1) / (2 * DIV);
        w = (n - 1) % (2 * DIV);
        if (k < l) begin
          e[0] = d[l-1-k];
          e[int'(t)] = (w >= DIV);
        end else begin
          e[0] = d[0];
        end
        check("shift_gpio", 32'(gpio_out), 32'(e));
        check("shift_done", 32'(done), 32'd0);
        check("shift_ready", 32'(cmd_ready), 32'd0);
      end else begin
        check("end_gpio", 32'(gpio_out), 32'd0);
        check("end_done", 32'(done), 32'd1);
        check("end_ready", 32'(cmd_ready), 32'd1);
        $display("shift tgt=%0d len=%0d done after %0d cycles", t, l, n);
      end
      check("shift_err", 32'(err), 32'd0);
      if (stop_at != 0 && n == stop_at) break;
    end
  endtask

  // Trigger pulse; optionally presents the next command during the pulse.
  task automatic expect_trig(input bit chain, input logic [7:0] nt, input logic [8:0] nl,
                             input logic [DATA_W-1:0] nd);
    for (int n = 1; n <= 2 * DIV + 1; n++) begin
      @(negedge clk);
      if (n == 1) begin
        cmd_valid = chain;
        cmd_target = nt;
        cmd_len = nl;
        cmd_data = nd;
      end
      if (n <= 2 * DIV) begin
        check("trig_gpio", 32'(gpio_out), 32'h040);
        check("trig_done", 32'(done), 32'd0);
        check("trig_ready", 32'(cmd_ready), 32'd0);
      end else begin
        check("trig_end_gpio", 32'(gpio_out), 32'd0);
        check("trig_end_done", 32'(done), 32'd1);
        check("trig_end_ready", 32'(cmd_ready), 32'd1);
      end
      check("trig_err", 32'(err), 32'd0);
    end
    $display("trigger done chain=%0d", chain);
  endtask

  task automatic expect_illegal(input logic [7:0] t, input logic [8:0] l);
    send(t, l, rand_word());
    @(negedge clk);
    cmd_valid = 1'b0;
    check("ill_err", 32'(err), 32'd1);
    check("ill_gpio", 32'(gpio_out), 32'd0);
    check("ill_ready", 32'(cmd_ready), 32'd1);
    check("ill_done", 32'(done), 32'd0);
    @(negedge clk);
    check("ill_err_off", 32'(err), 32'd0);
    check("ill_gpio2", 32'(gpio_out), 32'd0);
    check("ill_ready2", 32'(cmd_ready), 32'd1);
    $display("illegal tgt=%0d len=%0d err pulsed", t, l);
  endtask

  initial begin
    logic [DATA_W-1:0] d;
    logic [7:0] shift_tgts [6];
    logic [7:0] bad_tgts [4];
    logic [7:0] t;
    int l;
    shift_tgts = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd7, 8'd8};
    bad_tgts   = '{8'd0, 8'd5, 8'd9, 8'd200};

    // Reset state
    #2;
    check("rst_gpio", 32'(gpio_out), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    $display("reset released");

    // Select write
    d = '0; d[15:0] = 16'h0004;
    send(8'd2, 9'd16, d);
    expect_shift(8'd2, 16, d, 0);

    // Mux set, single bit
    d = '0; d[0] = 1'b1;
    send(8'd4, 9'd1, d);
    expect_shift(8'd4, 1, d, 0);

    // Full-width cycle count, 0xAAAA...
    for (int i = 0; i < DATA_W; i++) d[i] = (i % 2 == 1);
    send(8'd3, 9'd256, d);
    expect_shift(8'd3, 256, d, 0);

    // Illegal commands
    expect_illegal(8'd5, 9'd8);
    expect_illegal(8'd0, 9'd8);
    expect_illegal(8'd2, 9'd0);
    expect_illegal(8'd2, 9'd257);

    // Trigger with a target-1 command held during the pulse
    d = rand_word();
    send(8'd6, 9'd0, '0);
    expect_trig(1'b1, 8'd1, 9'd12, d);
    @(posedge clk);
    expect_shift(8'd1, 12, d, 0);

    // Reset mid-transfer
    d = rand_word();
    send(8'd2, 9'd16, d);
    expect_shift(8'd2, 16, d, 32);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_gpio", 32'(gpio_out), 32'd0);
    check("async_rst_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(cmd_ready), 32'd1);
    check("post_rst_gpio", 32'(gpio_out), 32'd0);
    $display("reset mid-transfer recovered");
    d = rand_word();
    send(8'd2, 9'd16, d);
    expect_shift(8'd2, 16, d, 0);

    // Randomized mix of commands
    for (int it = 0; it < 16; it++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 2) begin
        t = bad_tgts[$urandom_range(0, 3)];
        expect_illegal(t, 9'($urandom_range(1, 20)));
      end else if (r < 3) begin
        send(8'd6, 9'($urandom_range(0, 511)), rand_word());
        expect_trig(1'b0, 8'd0, 9'd0, '0);
      end else begin
        t = shift_tgts[$urandom_range(0, 5)];
        l = int'($urandom_range(1, 24));
        d = rand_word();
        send(t, 9'(l), d);
        expect_shift(t, l, d, 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
